// File: rtl/pet_io_pkg.sv
// pet_io_pkg: shared constants for the PET I/O page hub.
//   PET_IO_PAGE      high byte of the I/O page (0xE8xx)
//   HUB_REG_*        hub register offsets (addr[1:0])
//   *_BASE / *_MASK  default slot decode values for PIA1, PIA2, VIA and CRTC
//   hub_vec()        formats the IRQ_VEC register value
package pet_io_pkg;

  localparam logic [7:0] PET_IO_PAGE = 8'hE8;

  localparam logic [1:0] HUB_REG_IRQ_EN   = 2'd0;
  localparam logic [1:0] HUB_REG_IRQ_PEND = 2'd1;
  localparam logic [1:0] HUB_REG_IRQ_VEC  = 2'd2;
  localparam logic [1:0] HUB_REG_ERR      = 2'd3;

  localparam logic [7:0] PIA1_BASE = 8'h10;
  localparam logic [7:0] PIA1_MASK = 8'h10;
  localparam logic [7:0] PIA2_BASE = 8'h20;
  localparam logic [7:0] PIA2_MASK = 8'h20;
  localparam logic [7:0] VIA_BASE  = 8'h40;
  localparam logic [7:0] VIA_MASK  = 8'h40;
  localparam logic [7:0] CRTC_BASE = 8'h80;
  localparam logic [7:0] CRTC_MASK = 8'h80;

  function automatic logic [7:0] hub_vec(input logic valid, input logic [2:0] idx);
    return {valid, 4'b0000, idx};
  endfunction

endpackage

// File: rtl/pet_irq_ctrl.sv
// pet_irq_ctrl: interrupt enable/pending registers for the I/O hub.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   ch_irq        per-slot interrupt requests (active-high)
//   wr_en         write IRQ_EN with wdata
//   wr_pend       write-1-to-clear IRQ_PEND with wdata (edge slots only)
//   wdata         CPU write data
//   en, pend      current enable and pending vectors (for readback)
//   vec           IRQ_VEC value: {valid, 4'b0, lowest enabled pending index}
//   irq           registered OR of enabled pending bits
module pet_irq_ctrl
  import pet_io_pkg::*;
#(
  parameter int unsigned    NCH       = 4,
  parameter logic [NCH-1:0] EDGE_MASK = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] ch_irq,
  input  logic           wr_en,
  input  logic           wr_pend,
  input  logic [7:0]     wdata,
  output logic [NCH-1:0] en,
  output logic [NCH-1:0] pend,
  output logic [7:0]     vec,
  output logic           irq
);

  logic [NCH-1:0] en_q, edge_q, edge_d, ch_irq_q, rise, clr, act;
  logic           unused_wdata;

  assign unused_wdata = ^wdata;
  assign rise = ch_irq & ~ch_irq_q;
  assign clr  = wr_pend ? wdata[NCH-1:0] : '0;
  // Setting after clearing makes a simultaneous edge win over W1C.
  assign edge_d = ((edge_q & ~clr) | rise) & EDGE_MASK;
  // Level slots report the live request; edge slots report the latch.
  assign pend = (edge_q & EDGE_MASK) | (ch_irq & ~EDGE_MASK);
  assign en   = en_q;
  assign act  = pend & en_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q     <= '0;
      edge_q   <= '0;
      ch_irq_q <= '0;
      irq      <= 1'b0;
    end else begin
      ch_irq_q <= ch_irq;
      edge_q   <= edge_d;
      irq      <= |act;
      if (wr_en) en_q <= wdata[NCH-1:0];
    end
  end

  // Scan from the top so the lowest active index is the last assignment.
  always_comb begin
    vec = 8'h00;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (act[i]) vec = hub_vec(1'b1, 3'(i));
    end
  end

endmodule

// File: rtl/pet_io_hub.sv
// pet_io_hub: PET I/O page hub. Decodes the 256-byte I/O page into NCH slots by mask/match,
// strobes slots, merges read data (open-collector AND) onto a registered bus with a ready
// handshake, and hosts IRQ_EN / IRQ_PEND / IRQ_VEC / ERR registers at HUB_BASE..HUB_BASE+3.
// Optional feature macro: IO_HUB_BUSERR_EN (bus error pulse and sticky ERR register).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ce                  CPU clock enable (strobes use ce delayed one cycle)
//   addr, data_in       I/O page offset, CPU write data
//   cs, we              page select, write
//   data_out, rdy       registered read data, read-data-valid
//   irq                 any enabled pending slot interrupt
//   ch_sel, ch_strobe   per-slot decode hit, per-slot access strobe
//   ch_data_in, ch_irq  per-slot read data (slot 0 in LSBs), per-slot interrupt
//   bus_err             one-cycle pulse on unmapped access
module pet_io_hub
  import pet_io_pkg::*;
#(
  parameter int unsigned      NCH       = 4,
  parameter logic [NCH*8-1:0] CH_BASE   = {CRTC_BASE, VIA_BASE, PIA2_BASE, PIA1_BASE},
  parameter logic [NCH*8-1:0] CH_MASK   = {CRTC_MASK, VIA_MASK, PIA2_MASK, PIA1_MASK},
  parameter logic [NCH-1:0]   EDGE_MASK = '0,
  parameter logic [7:0]       HUB_BASE  = 8'hF0,
  parameter int unsigned      RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [7:0]       addr,
  input  logic [7:0]       data_in,
  input  logic             cs,
  input  logic             we,
  output logic [7:0]       data_out,
  output logic             rdy,
  output logic             irq,
  output logic [NCH-1:0]   ch_sel,
  output logic [NCH-1:0]   ch_strobe,
  input  logic [NCH*8-1:0] ch_data_in,
  input  logic [NCH-1:0]   ch_irq,
  output logic             bus_err
);

  logic           ce_d_q, cs_q, hub_hit, acc, hub_wr;
  logic [NCH-1:0] hit, irq_en, irq_pend;
  logic [7:0]     irq_vec, err_rd, hub_rdata, rdata;
  logic [2:0]     lat_q, lat_d;

  assign hub_hit = addr[7:2] == HUB_BASE[7:2];

  // Hub registers shadow any slot whose mask/match would also cover them.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      hit[i] = !hub_hit && ((addr & CH_MASK[i*8 +: 8]) == CH_BASE[i*8 +: 8]);
    end
  end

  assign ch_sel    = hit;
  assign acc       = ce_d_q & cs;
  assign ch_strobe = {NCH{acc}} & hit;
  assign hub_wr    = acc & we & hub_hit;

  pet_irq_ctrl #(
    .NCH       (NCH),
    .EDGE_MASK (EDGE_MASK)
  ) u_irq_ctrl (
    .clk     (clk),
    .reset   (reset),
    .ch_irq  (ch_irq),
    .wr_en   (hub_wr && addr[1:0] == HUB_REG_IRQ_EN),
    .wr_pend (hub_wr && addr[1:0] == HUB_REG_IRQ_PEND),
    .wdata   (data_in),
    .en      (irq_en),
    .pend    (irq_pend),
    .vec     (irq_vec),
    .irq     (irq)
  );

  always_comb begin
    hub_rdata = 8'hFF;
    case (addr[1:0])
      HUB_REG_IRQ_EN:   hub_rdata = 8'(irq_en);
      HUB_REG_IRQ_PEND: hub_rdata = 8'(irq_pend);
      HUB_REG_IRQ_VEC:  hub_rdata = irq_vec;
      default:          hub_rdata = err_rd;
    endcase
  end

  // Open-collector merge: every hit source can only pull bits low.
  always_comb begin
    rdata = 8'hFF;
    for (int i = 0; i < int'(NCH); i++) begin
      if (hit[i]) rdata = rdata & ch_data_in[i*8 +: 8];
    end
    if (hub_hit) rdata = rdata & hub_rdata;
  end

  always_comb begin
    lat_d = lat_q;
    if (!cs) begin
      lat_d = '0;
    end else if (!cs_q && !we) begin
      lat_d = 3'(RD_LAT);
    end else if (lat_q != 3'd0) begin
      lat_d = lat_q - 3'd1;
    end
  end

  assign rdy = lat_q == 3'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_d_q   <= 1'b0;
      cs_q     <= 1'b0;
      lat_q    <= '0;
      data_out <= 8'hFF;
    end else begin
      ce_d_q <= ce;
      cs_q   <= cs;
      lat_q  <= lat_d;
      if (cs) data_out <= rdata;
    end
  end

`ifdef IO_HUB_BUSERR_EN
  logic       unmapped, bus_err_q;
  logic [7:0] err_q;

  assign unmapped = cs & ~hub_hit & ~(|hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err_q <= 1'b0;
      err_q     <= 8'h00;
    end else begin
      bus_err_q <= ce_d_q & unmapped;
      if (ce_d_q & unmapped) begin
        err_q <= {1'b1, addr[6:0]};
      end else if (acc && !we && hub_hit && addr[1:0] == HUB_REG_ERR) begin
        err_q[7] <= 1'b0;
      end
    end
  end

  assign bus_err = bus_err_q;
  assign err_rd  = err_q;
`else
  assign bus_err = 1'b0;
  assign err_rd  = 8'hFF;
`endif

endmodule

// File: tb/tb_pet_io_hub.sv
module tb_pet_io_hub;

  logic        clk = 1'b0;
  logic        reset, ce, cs, we;
  logic [7:0]  addr, data_in, data_out;
  logic        rdy, irq, bus_err;
  logic [3:0]  ch_sel, ch_strobe, ch_irq;
  logic [31:0] ch_data_in;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] d;
  logic [3:0] stb, sel;
  logic       rdy_a, rdy_b, be;

  always #5 clk = ~clk;

  pet_io_hub #(
    .EDGE_MASK (4'b0001)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .addr       (addr),
    .data_in    (data_in),
    .cs         (cs),
    .we         (we),
    .data_out   (data_out),
    .rdy        (rdy),
    .irq        (irq),
    .ch_sel     (ch_sel),
    .ch_strobe  (ch_strobe),
    .ch_data_in (ch_data_in),
    .ch_irq     (ch_irq),
    .bus_err    (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read: cs held for two edges; strobe/rdy sampled between them, data after the second.
  task automatic bus_read(input logic [7:0] a, output logic [7:0] rd, output logic [3:0] s,
                          output logic [3:0] sl, output logic ra, output logic rb,
                          output logic e);
    @(negedge clk); addr = a; we = 1'b0; cs = 1'b1; ce = 1'b1;
    @(negedge clk); ce = 1'b0; s = ch_strobe; sl = ch_sel; ra = rdy;
    @(negedge clk); rb = rdy; rd = data_out; e = bus_err; cs = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] v, output logic [3:0] s,
                           output logic rw);
    @(negedge clk); addr = a; data_in = v; we = 1'b1; cs = 1'b1; ce = 1'b1;
    @(negedge clk); ce = 1'b0; s = ch_strobe; rw = rdy;
    @(negedge clk); cs = 1'b0; we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; cs = 1'b0; we = 1'b0;
    addr = 8'h00; data_in = 8'h00; ch_irq = 4'b0000;
    ch_data_in = {8'h33, 8'h22, 8'h11, 8'h5A};
    repeat (2) @(negedge clk);
    chk("reset data_out", data_out, 8'hFF);
    chk("reset rdy", rdy, 1'b1);
    chk("reset irq", irq, 1'b0);
    chk("reset strobe", ch_strobe, 4'b0000);
    chk("reset bus_err", bus_err, 1'b0);
    reset = 1'b0;

    // Single-slot read
    bus_read(8'h10, d, stb, sel, rdy_a, rdy_b, be);
    chk("rd10 rdy low", rdy_a, 1'b0);
    chk("rd10 rdy back", rdy_b, 1'b1);
    chk("rd10 strobe", stb, 4'b0001);
    chk("rd10 sel", sel, 4'b0001);
    chk("rd10 data", d, 8'h5A);

    // Two slots hit: AND merge
    ch_data_in = {8'h33, 8'h22, 8'h3C, 8'hF0};
    bus_read(8'h30, d, stb, sel, rdy_a, rdy_b, be);
    chk("rd30 strobe", stb, 4'b0011);
    chk("rd30 data", d, 8'h30);

    // Enable slots 0 and 2, level IRQ on slot 2
    bus_write(8'hF0, 8'h05, stb, rdy_a);
    chk("wr en strobe", stb, 4'b0000);
    chk("wr en rdy", rdy_a, 1'b1);
    @(negedge clk); ch_irq = 4'b0100;
    @(negedge clk);
    chk("lvl irq set", irq, 1'b1);
    bus_read(8'hF2, d, stb, sel, rdy_a, rdy_b, be);
    chk("vec slot2", d, 8'h82);
    bus_read(8'hF1, d, stb, sel, rdy_a, rdy_b, be);
    chk("pend slot2", d, 8'h04);
    @(negedge clk); ch_irq = 4'b0010;
    @(negedge clk);
    chk("masked irq", irq, 1'b0);
    bus_read(8'hF2, d, stb, sel, rdy_a, rdy_b, be);
    chk("vec none", d, 8'h00);

    // Edge-latched slot 0
    @(negedge clk); ch_irq = 4'b0001;
    @(negedge clk); ch_irq = 4'b0000;
    @(negedge clk);
    chk("edge irq", irq, 1'b1);
    bus_read(8'hF1, d, stb, sel, rdy_a, rdy_b, be);
    chk("edge pend", d, 8'h01);
    bus_read(8'hF2, d, stb, sel, rdy_a, rdy_b, be);
    chk("vec slot0", d, 8'h80);
    bus_write(8'hF1, 8'h01, stb, rdy_a);
    bus_read(8'hF1, d, stb, sel, rdy_a, rdy_b, be);
    chk("w1c clears", d, 8'h00);
    chk("w1c irq", irq, 1'b0);

    // Edge arrives on the same clock as the W1C write: set wins
    @(negedge clk); addr = 8'hF1; data_in = 8'h01; we = 1'b1; cs = 1'b1; ce = 1'b1;
    @(negedge clk); ce = 1'b0; ch_irq = 4'b0001;
    @(negedge clk); cs = 1'b0; we = 1'b0; ch_irq = 4'b0000;
    bus_read(8'hF1, d, stb, sel, rdy_a, rdy_b, be);
    chk("set beats clr", d, 8'h01);

    // Hub write never strobes a slot; upper enable bits read 0
    bus_write(8'hF0, 8'h77, stb, rdy_a);
    chk("hub wr strobe", stb, 4'b0000);
    bus_read(8'hF0, d, stb, sel, rdy_a, rdy_b, be);
    chk("en readback", d, 8'h07);
    chk("hub rd strobe", stb, 4'b0000);
    chk("pend irq", irq, 1'b1);

    // Reset in the middle of an access
    ch_data_in = {8'h33, 8'h22, 8'h11, 8'h5A};
    @(negedge clk); addr = 8'h10; we = 1'b0; cs = 1'b1; ce = 1'b1; reset = 1'b1;
    @(negedge clk);
    chk("rst strobe", ch_strobe, 4'b0000);
    chk("rst rdy", rdy, 1'b1);
    chk("rst data", data_out, 8'hFF);
    chk("rst irq", irq, 1'b0);
    reset = 1'b0; ce = 1'b0; cs = 1'b0;

    // Unmapped access
    bus_read(8'h01, d, stb, sel, rdy_a, rdy_b, be);
    chk("unmapped data", d, 8'hFF);
    chk("unmapped strobe", stb, 4'b0000);
`ifdef IO_HUB_BUSERR_EN
    chk("bus_err pulse", be, 1'b1);
    @(negedge clk);
    chk("bus_err gone", bus_err, 1'b0);
    bus_read(8'hF3, d, stb, sel, rdy_a, rdy_b, be);
    chk("err first", d, 8'h81);
    bus_read(8'hF3, d, stb, sel, rdy_a, rdy_b, be);
    chk("err reread", d, 8'h01);
`else
    chk("no bus_err", be, 1'b0);
    bus_read(8'hF3, d, stb, sel, rdy_a, rdy_b, be);
    chk("err reg ff", d, 8'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
